fir_interpolator: RTL and testbench



---
 rtl/sdm_filter_pkg.sv | 49 ++++
 rtl/fir_interpolator.sv | 144 ++++++++++++++
 tb/tb_fir_interpolator.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdm_filter_pkg.sv
// Shared definitions for the sigma-delta chain filters (interpolator and decimator):
// sample/coefficient widths, default kernel, FSM states and the shift-and-saturate helper.
package sdm_filter_pkg;

    localparam int SAMPLE_W    = 16;
    localparam int COEFF_W     = 16;
    localparam int DEFAULT_L   = 4;
    localparam int DEFAULT_TPP = 2;

    // Linear-interpolation (triangular) kernel in Q1.14 for L=4, TPP=2.
    localparam logic signed [COEFF_W-1:0] DEFAULT_COEFFS [DEFAULT_L*DEFAULT_TPP] = '{
        16'sd0, 16'sd4096, 16'sd8192, 16'sd12288,
        16'sd16384, 16'sd12288, 16'sd8192, 16'sd4096
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    typedef struct packed {
        logic                       sat;
        logic signed [SAMPLE_W-1:0] value;
    } sat_res_t;

    localparam logic signed [63:0] SAT_MAX = 64'sd32767;
    localparam logic signed [63:0] SAT_MIN = -64'sd32768;

    // Floor shift (arithmetic) followed by clipping to the sample range.
    function automatic sat_res_t sat_shift(input logic signed [63:0] acc,
                                           input int unsigned       frac);
        logic signed [63:0] sh;
        sat_res_t           res;
        sh = acc >>> frac;
        if (sh > SAT_MAX) begin
            res.sat   = 1'b1;
            res.value = SAT_MAX[SAMPLE_W-1:0];
        end else if (sh < SAT_MIN) begin
            res.sat   = 1'b1;
            res.value = SAT_MIN[SAMPLE_W-1:0];
        end else begin
            res.sat   = 1'b0;
            res.value = sh[SAMPLE_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_interpolator.sv
// Polyphase FIR interpolator: one input sample produces L outputs, each computed
// with a single time-shared multiplier over TPP taps, valid/ready on both sides.
module fir_interpolator
    import sdm_filter_pkg::*;
#(
    parameter int L          = 4,
    parameter int TPP        = 2,
    parameter int COEFF_FRAC = 14,
    parameter logic signed [COEFF_W-1:0] COEFFS [L*TPP] = DEFAULT_COEFFS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    output logic                       ready_in,
    input  logic signed [SAMPLE_W-1:0] din,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic signed [SAMPLE_W-1:0] dout,
    output logic [$clog2(L)-1:0]       phase_out,
    output logic                       sat_out
);

    localparam int PH_W  = $clog2(L);
    localparam int TAP_W = (TPP > 1) ? $clog2(TPP) : 1;
    localparam int ACC_W = 32 + $clog2(TPP);
    localparam int IDX_W = $clog2(L*TPP);

    state_e                      state_q, state_d;
    logic [PH_W-1:0]             phase_q, phase_d;
    logic [TAP_W-1:0]            tap_q, tap_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic                        valid_out_q, valid_out_d;
    logic signed [SAMPLE_W-1:0]  dout_q, dout_d;
    logic [PH_W-1:0]             phase_out_q, phase_out_d;
    logic                        sat_q, sat_d;
    logic signed [SAMPLE_W-1:0]  x_q [TPP];

    logic                        accept;
    logic [IDX_W-1:0]            coef_idx;
    logic signed [SAMPLE_W-1:0]  x_sel;
    logic signed [31:0]          prod;
    logic signed [ACC_W-1:0]     acc_sum;
    sat_res_t                    res;

    assign ready_in  = (state_q == IDLE);
    assign accept    = valid_in && ready_in;
    assign valid_out = valid_out_q;
    assign dout      = dout_q;
    assign phase_out = phase_out_q;
    assign sat_out   = sat_q;

    // L is a power of two, so tap*L + phase is a plain concatenation.
    assign coef_idx = IDX_W'({tap_q, phase_q});
    assign x_sel    = x_q[tap_q];
    assign prod     = COEFFS[coef_idx] * x_sel;
    assign acc_sum  = acc_q + ACC_W'(prod);
    assign res      = sat_shift(64'(acc_sum), COEFF_FRAC);

    generate
        for (genvar gi = 0; gi < TPP; gi++) begin : g_delay
            always_ff @(posedge clk) begin
                if (rst) begin
                    x_q[gi] <= '0;
                end else if (accept) begin
                    if (gi == 0) begin
                        x_q[gi] <= din;
                    end else begin
                        x_q[gi] <= x_q[(gi > 0) ? gi - 1 : 0];
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        valid_out_d = valid_out_q;
        dout_d      = dout_q;
        phase_out_d = phase_out_q;
        sat_d       = sat_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    phase_d = '0;
                    tap_d   = '0;
                    acc_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_sum;
                if (tap_q == TAP_W'(TPP - 1)) begin
                    dout_d      = res.value;
                    sat_d       = res.sat;
                    phase_out_d = phase_q;
                    valid_out_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            OUT: begin
                if (ready_out) begin
                    valid_out_d = 1'b0;
                    if (phase_q == PH_W'(L - 1)) begin
                        state_d = IDLE;
                    end else begin
                        phase_d = phase_q + 1'b1;
                        tap_d   = '0;
                        acc_d   = '0;
                        state_d = MAC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            tap_q       <= '0;
            acc_q       <= '0;
            valid_out_q <= 1'b0;
            dout_q      <= '0;
            phase_out_q <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            valid_out_q <= valid_out_d;
            dout_q      <= dout_d;
            phase_out_q <= phase_out_d;
            sat_q       <= sat_d;
        end
    end

endmodule

// File: tb/tb_fir_interpolator.sv
// Directed bench: default interpolator plus a COEFF_FRAC=13 copy sharing the same stimulus.
module tb_fir_interpolator;

    logic               clk = 1'b0;
    logic               rst;
    logic               valid_in;
    logic signed [15:0] din;
    logic               ready_out;

    logic               ready_in, valid_out, sat_out;
    logic signed [15:0] dout;
    logic [1:0]         phase_out;

    logic               ready_in_s, valid_out_s, sat_out_s;
    logic signed [15:0] dout_s;
    logic [1:0]         phase_out_s;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int accept_cyc = 0;

    logic signed [15:0] cap_d [4];
    logic signed [15:0] cap_ds [4];
    logic [1:0]         cap_p [4];
    logic               cap_s [4];
    logic               cap_ss [4];
    int                 cap_lat [4];
    bit                 cap_to;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_interpolator dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in), .din(din),
        .valid_out(valid_out), .ready_out(ready_out), .dout(dout),
        .phase_out(phase_out), .sat_out(sat_out)
    );

    fir_interpolator #(.COEFF_FRAC(13)) dut_sat (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in_s), .din(din),
        .valid_out(valid_out_s), .ready_out(ready_out), .dout(dout_s),
        .phase_out(phase_out_s), .sat_out(sat_out_s)
    );

    task automatic do_reset();
        rst = 1'b1; valid_in = 1'b0; din = '0; ready_out = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Presents a sample until accepted; returns just after the accepting edge.
    task automatic send(input logic signed [15:0] v, output bit ok);
        bit rdy;
        ok = 1'b0;
        valid_in = 1'b1;
        din = v;
        for (int i = 0; i < 40 && !ok; i++) begin
            rdy = ready_in;
            @(posedge clk);
            if (rdy) accept_cyc = cyc;
            #1;
            if (rdy) ok = 1'b1;
        end
        valid_in = 1'b0;
        din = 16'sh7abc;
    endtask

    task automatic wait_valid(output int cnt, output bit to);
        cnt = 0;
        while (!valid_out && cnt < 50) begin
            @(posedge clk); #1; cnt++;
        end
        to = !valid_out;
    endtask

    // Drains phases first..3 with ready_out high, capturing outputs of both copies.
    task automatic get_outputs(input int first);
        bit to;
        cap_to = 1'b0;
        ready_out = 1'b1;
        for (int k = first; k < 4; k++) begin
            wait_valid(cap_lat[k], to);
            if (to) cap_to = 1'b1;
            cap_d[k] = dout;  cap_p[k] = phase_out; cap_s[k] = sat_out;
            cap_ds[k] = dout_s; cap_ss[k] = sat_out_s;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (ready_in !== 1'b1 || ready_in_s !== 1'b1) begin
            tests_failed++; $display("FAIL reset_ready_in got %b/%b exp 1", ready_in, ready_in_s);
        end
        tests_run++;
        if (valid_out !== 1'b0 || valid_out_s !== 1'b0) begin
            tests_failed++; $display("FAIL reset_valid_out got %b/%b exp 0", valid_out, valid_out_s);
        end
        tests_run++;
        if (dout !== 16'sd0) begin
            tests_failed++; $display("FAIL reset_dout got %0d exp 0", dout);
        end
        tests_run++;
        if (phase_out !== 2'd0 || phase_out_s !== 2'd0) begin
            tests_failed++; $display("FAIL reset_phase_out got %0d exp 0", phase_out);
        end
        tests_run++;
        if (sat_out !== 1'b0) begin
            tests_failed++; $display("FAIL reset_sat_out got %b exp 0", sat_out);
        end
        $display("[TB] reset: ready_in=%b valid_out=%b dout=%0d", ready_in, valid_out, dout);
    endtask

    task automatic test_ramp();
        bit ok;
        int exp_d [4] = '{0, 250, 500, 750};
        send(16'sd0, ok);    get_outputs(0);
        send(16'sd1000, ok); get_outputs(0);
        tests_run++;
        if (!ok || cap_to) begin
            tests_failed++; $display("FAIL ramp_handshake accepted=%b timeout=%b exp 1/0", ok, cap_to);
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (cap_d[k] !== 16'(exp_d[k]) || cap_p[k] !== 2'(k) || cap_s[k] !== 1'b0) begin
                tests_failed++;
                $display("FAIL ramp_phase%0d got dout=%0d phase=%0d sat=%b exp dout=%0d phase=%0d sat=0",
                         k, cap_d[k], cap_p[k], cap_s[k], exp_d[k], k);
            end
            $display("[TB] ramp: phase=%0d dout=%0d sat=%b", cap_p[k], cap_d[k], cap_s[k]);
        end
    endtask

    task automatic test_dc_and_step();
        bit ok;
        int exp_n [4] = '{0, -250, -500, -750};
        for (int i = 0; i < 3; i++) begin
            send(16'sd1000, ok); get_outputs(0);
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (cap_d[k] !== 16'sd1000 || cap_p[k] !== 2'(k) || cap_to) begin
                tests_failed++;
                $display("FAIL dc_phase%0d got dout=%0d phase=%0d exp dout=1000 phase=%0d", k, cap_d[k], cap_p[k], k);
            end
            $display("[TB] dc: phase=%0d dout=%0d", cap_p[k], cap_d[k]);
        end
        send(16'sd0, ok); get_outputs(0);
        send(-16'sd1000, ok); get_outputs(0);
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (cap_d[k] !== 16'(exp_n[k]) || cap_p[k] !== 2'(k) || cap_to) begin
                tests_failed++;
                $display("FAIL negstep_phase%0d got dout=%0d exp %0d", k, cap_d[k], exp_n[k]);
            end
            $display("[TB] negstep: phase=%0d dout=%0d", cap_p[k], cap_d[k]);
        end
    endtask

    task automatic test_backpressure();
        bit ok, to;
        int cnt;
        send(16'sd0, ok); get_outputs(0);
        send(16'sd1000, ok);
        ready_out = 1'b1;
        wait_valid(cnt, to);
        @(posedge clk); #1;           // phase 0 handshake
        ready_out = 1'b0;
        wait_valid(cnt, to);
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (to || valid_out !== 1'b1 || dout !== 16'sd250 || phase_out !== 2'd1 || ready_in !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure_hold cycle %0d got valid=%b dout=%0d phase=%0d ready_in=%b exp 1/250/1/0",
                         c, valid_out, dout, phase_out, ready_in);
            end
            $display("[TB] stall: cycle=%0d valid=%b dout=%0d", c, valid_out, dout);
            @(posedge clk); #1;
        end
        get_outputs(1);
        tests_run++;
        if (cap_to || cap_d[1] !== 16'sd250 || cap_d[2] !== 16'sd500 || cap_d[3] !== 16'sd750
            || cap_p[2] !== 2'd2 || cap_p[3] !== 2'd3) begin
            tests_failed++;
            $display("FAIL backpressure_resume got %0d,%0d,%0d phases %0d,%0d exp 250,500,750 phases 2,3",
                     cap_d[1], cap_d[2], cap_d[3], cap_p[2], cap_p[3]);
        end
        $display("[TB] resume: dout=%0d,%0d,%0d", cap_d[1], cap_d[2], cap_d[3]);
        // No extra output may follow the fourth phase.
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (valid_out) cnt++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (cnt != 0 || ready_in !== 1'b1) begin
            tests_failed++; $display("FAIL backpressure_extra got %0d extra valid, ready_in=%b exp 0,1", cnt, ready_in);
        end
    endtask

    task automatic test_timing();
        bit ok;
        int first_acc;
        send(16'sd0, ok);
        first_acc = accept_cyc;
        get_outputs(0);
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            // Handshake edge lands cap_lat+1 edges after the accept/previous handshake.
            if (cap_lat[k] + 1 != 3) begin
                tests_failed++;
                $display("FAIL timing_latency phase%0d got %0d cycles exp 3", k, cap_lat[k] + 1);
            end
            $display("[TB] timing: phase=%0d handshake after %0d cycles", k, cap_lat[k] + 1);
        end
        tests_run++;
        if (ready_in !== 1'b1) begin
            tests_failed++; $display("FAIL timing_ready_return got %b exp 1", ready_in);
        end
        send(16'sd0, ok);
        tests_run++;
        if (!ok || accept_cyc - first_acc != 13) begin
            tests_failed++; $display("FAIL timing_interval got %0d cycles exp 13", accept_cyc - first_acc);
        end
        $display("[TB] timing: accept interval=%0d", accept_cyc - first_acc);
        get_outputs(0);
    endtask

    task automatic test_saturation();
        bit ok;
        send(16'sd20000, ok); get_outputs(0);
        send(16'sd20000, ok); get_outputs(0);
        tests_run++;
        if (cap_to || cap_ds[0] !== 16'sd32767 || cap_ss[0] !== 1'b1) begin
            tests_failed++; $display("FAIL sat_pos got dout=%0d sat=%b exp 32767/1", cap_ds[0], cap_ss[0]);
        end
        tests_run++;
        if (cap_d[0] !== 16'sd20000 || cap_s[0] !== 1'b0) begin
            tests_failed++; $display("FAIL sat_none got dout=%0d sat=%b exp 20000/0", cap_d[0], cap_s[0]);
        end
        $display("[TB] sat: frac13 dout=%0d sat=%b frac14 dout=%0d", cap_ds[0], cap_ss[0], cap_d[0]);
        send(-16'sd20000, ok); get_outputs(0);
        send(-16'sd20000, ok); get_outputs(0);
        tests_run++;
        if (cap_to || cap_ds[0] !== -16'sd32768 || cap_ss[0] !== 1'b1) begin
            tests_failed++; $display("FAIL sat_neg got dout=%0d sat=%b exp -32768/1", cap_ds[0], cap_ss[0]);
        end
        $display("[TB] sat: frac13 dout=%0d sat=%b", cap_ds[0], cap_ss[0]);
    endtask

    task automatic test_reset_mid();
        bit ok, to;
        int cnt;
        int exp_d [4] = '{0, 100, 200, 300};
        send(16'sd1000, ok);
        ready_out = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_valid(cnt, to);
            @(posedge clk); #1;
        end
        rst = 1'b1;                 // now inside phase 2 MAC
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run++;
        if (valid_out !== 1'b0 || ready_in !== 1'b1) begin
            tests_failed++; $display("FAIL midreset_state got valid=%b ready_in=%b exp 0/1", valid_out, ready_in);
        end
        send(16'sd400, ok); get_outputs(0);
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (cap_to || cap_d[k] !== 16'(exp_d[k]) || cap_p[k] !== 2'(k)) begin
                tests_failed++;
                $display("FAIL midreset_phase%0d got dout=%0d phase=%0d exp %0d/%0d", k, cap_d[k], cap_p[k], exp_d[k], k);
            end
            $display("[TB] midreset: phase=%0d dout=%0d", cap_p[k], cap_d[k]);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_dc_and_step();
        test_backpressure();
        test_timing();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
